// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: the memory-mapped
// UART address, the FSM state encoding and the default bit period.
package uart_tx_buffered_pkg;

  // CPU store address that is decoded upstream into wr_en.
  localparam logic [31:0] UART_ADDR = 32'h1000_0000;

  // 125 MHz / 115200 baud.
  localparam int DEFAULT_BAUD_DIV = 1085;

  // 2-bit FSM state encodings.
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_START = ST_START_ENC,
    S_DATA  = ST_DATA_ENC,
    S_STOP  = ST_STOP_ENC
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push is accepted while the
// FIFO is not full, or when a pop happens in the same cycle; a simultaneous
// push and pop leave the occupancy unchanged.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr];

  // Storage array: written on an accepted push.
  // NOTE: the data array has no reset; only pointers and count need a known state.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. CPU stores are queued in a FIFO and the FSM
// serialises them LSB first; back-to-back frames are sent with no idle gap.
// A sticky overflow flag records any byte dropped because the FIFO was full.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  tx_state_e         r_state;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_overflow;

  tx_state_e         w_state_nxt;
  logic [CNT_W-1:0]  w_baud_nxt;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_tx_nxt;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_data;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_en),
    .i_data  (wr_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  // Next-state logic: bit timing, shifting and FIFO pops.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == BIT_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit_idx + BIT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_fifo_empty) begin
            // Streamed frame: the next start bit follows the stop bit directly.
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_bit_nxt   = '0;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Line level for the cycle after the edge, registered so uart_tx cannot glitch.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // State register, datapath and sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      if (wr_en && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign uart_tx  = r_tx;
  assign busy     = !w_fifo_empty || (r_state != S_IDLE);
  assign full     = w_fifo_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered with BAUD_DIV=4, FIFO_DEPTH=4.
// A logger records uart_tx and busy once per cycle; expected line waveforms
// are built from hand-computed 10-bit frames expanded to 4 cycles per bit.
module tb_uart_tx_buffered;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * BD;
  localparam int LOG_N = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uart_tx, busy, full, overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic tx_log   [LOG_N];
  logic busy_log [LOG_N];
  logic [9:0] exp_frames [8];

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] frame;  // time order: bit 0 is the start bit, bit 9 the stop bit
  } vec_t;
  vec_t vecs [5];

  uart_tx_buffered #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH),
    .DATA_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Sample the outputs shortly after every rising edge; index = edge number.
  always @(posedge clk) begin
    #2;
    if (cyc < LOG_N) begin
      tx_log[cyc]   = uart_tx;
      busy_log[cyc] = busy;
    end
    cyc = cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Compare n contiguous frames starting at logged cycle 'start' against exp_frames.
  task automatic check_stream(input string name, input int start, input int n);
    while (cyc <= start + FLEN * n) @(negedge clk);
    check({name, " line idle before start"}, 64'(tx_log[start-1]), 64'd1);
    for (int f = 0; f < n; f++) begin
      logic [39:0] act;
      logic [39:0] exp;
      for (int i = 0; i < FLEN; i++) begin
        act[i] = tx_log[start + FLEN * f + i];
        exp[i] = exp_frames[f][i / BD];
      end
      check($sformatf("%s frame%0d", name, f), 64'(act), 64'(exp));
    end
    check({name, " line idle after"}, 64'(tx_log[start + FLEN * n]), 64'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n0;

    vecs[0] = '{"byte A5", 8'hA5, 10'b11_0100_1010};
    vecs[1] = '{"byte 00", 8'h00, 10'b10_0000_0000};
    vecs[2] = '{"byte FF", 8'hFF, 10'b11_1111_1110};
    vecs[3] = '{"byte 5A", 8'h5A, 10'b10_1011_0100};
    vecs[4] = '{"byte 01", 8'h01, 10'b10_0000_0010};

    // 1. Reset state, and the line stays idle with no writes.
    repeat (3) @(negedge clk);
    check("reset uart_tx", 64'(uart_tx), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset flags", 64'({busy, full, overflow}), 64'd0);
    n0 = cyc;
    repeat (8) @(negedge clk);
    begin
      logic [7:0] idle_bits;
      for (int i = 0; i < 8; i++) idle_bits[i] = tx_log[n0 + i];
      check("idle line", 64'(idle_bits), 64'hFF);
    end

    // 2. Single bytes from the table; busy falls the cycle after the stop bit.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      n0 = cyc;
      wr_en = 1'b1;
      wr_data = vecs[v].data;
      @(negedge clk);
      wr_en = 1'b0;
      exp_frames[0] = vecs[v].frame;
      check_stream(vecs[v].name, n0 + 1, 1);
      check({vecs[v].name, " busy in stop"}, 64'(busy_log[n0 + FLEN]), 64'd1);
      check({vecs[v].name, " busy after"}, 64'(busy_log[n0 + FLEN + 1]), 64'd0);
    end

    // 3. Burst of three writes on consecutive cycles -> contiguous frames.
    @(negedge clk);
    n0 = cyc;
    wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'(i);
      exp_frames[i-1] = frame_of(8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    check_stream("burst", n0 + 1, 3);

    // 4. Six consecutive writes: 8'h15 finds the FIFO full and is dropped.
    @(negedge clk);
    n0 = cyc;
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h10 + 8'(i);
      if (i < 5) exp_frames[i] = frame_of(8'h10 + 8'(i));
      if (i == 5) check("overflow before drop", 64'({full, overflow}), 64'b10);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("overflow after drop", 64'({full, overflow}), 64'b11);
    check_stream("overflow stream", n0 + 1, 5);
    repeat (4) @(negedge clk);
    check("overflow sticky, idle", 64'({busy, overflow}), 64'b01);
    reset_pulse();
    @(negedge clk);
    check("overflow cleared by reset", 64'(overflow), 64'd0);

    // 5. FIFO full, write lands in the same cycle as the end-of-stop pop.
    @(negedge clk);
    n0 = cyc;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) exp_frames[i] = frame_of(8'hC0 + 8'(i));
    while (cyc < n0 + 1 + FLEN) @(negedge clk);
    check("full before pop", 64'({full, overflow}), 64'b10);
    wr_en = 1'b1;
    wr_data = 8'hC5;
    @(negedge clk);
    wr_en = 1'b0;
    check("full after push+pop", 64'({full, overflow}), 64'b10);
    check_stream("full plus pop", n0 + 1, 6);
    check("no overflow on push+pop", 64'(overflow), 64'd0);

    // 6. Reset during DATA bit 3 of 8'hC3 with a second byte queued.
    @(negedge clk);
    n0 = cyc;
    wr_en = 1'b1;
    wr_data = 8'hC3;
    @(negedge clk);
    wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    // Bit 3 occupies logged cycles n0+17 .. n0+20.
    while (cyc < n0 + 19) @(negedge clk);
    check("mid-frame bit3 level", 64'(uart_tx), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("reset mid-frame line", 64'(uart_tx), 64'd1);
    check("reset mid-frame fifo", 64'({busy, full}), 64'b00);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("after abort idle", 64'({uart_tx, busy}), 64'b10);
    @(negedge clk);
    n0 = cyc;
    wr_en = 1'b1;
    wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    exp_frames[0] = 10'b10_1011_0100;
    check_stream("after reset 5A", n0 + 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
